// File: rtl/timer_dev_if.sv
// Bus-side port bundle of the programmable down-counter timer.
// The bridge (master) drives the word select, write strobe and write data;
// the timer (slave) returns combinational read data and its interrupt request.
interface timer_dev_if;
    logic [1:0]  addr;
    logic        we;
    logic [31:0] din;
    logic [31:0] dout;
    logic        irq;

    modport master (
        output addr,
        output we,
        output din,
        input  dout,
        input  irq
    );

    modport slave (
        input  addr,
        input  we,
        input  din,
        output dout,
        output irq
    );
endinterface

// File: rtl/timer_dev.sv
// Memory-mapped programmable down-counter timer.
// Three word registers: CTRL {im, mode[1:0], en}, PRESET (reload value) and
// COUNT (read-only current value). The counter runs PRESET down to zero and
// raises an interrupt flag, either one-shot and held until software writes
// CTRL/PRESET (mode 0, and the aliases 2/3), or as a one-cycle pulse with
// automatic reload (mode 1). A CTRL/PRESET write always wins over the counting
// sequence in the same cycle, sends it back to idle and clears the flag.
module timer_dev (
    input  logic       clk,
    input  logic       reset,
    timer_dev_if.slave bus
);

    // Word select encoding on the bus.
    localparam logic [1:0] ADDR_CTRL   = 2'd0;
    localparam logic [1:0] ADDR_PRESET = 2'd1;
    localparam logic [1:0] ADDR_COUNT  = 2'd2;

    // Mode value that selects periodic auto-reload; every other mode is one-shot.
    localparam logic [1:0] MODE_PERIODIC = 2'd1;

    typedef enum logic [1:0] {
        S_IDLE,
        S_LOAD,
        S_CNT,
        S_INT
    } state_t;

    state_t      r_state;
    logic        r_en;
    logic [1:0]  r_mode;
    logic        r_im;
    logic [31:0] r_preset;
    logic [31:0] r_count;
    logic        r_irqFlag;

    logic        w_ctrlWrite;
    logic        w_presetWrite;
    logic        w_cfgWrite;
    logic        w_autoReload;
    logic        w_lastTick;
    logic [31:0] w_ctrlRead;
    logic [31:0] w_readData;

    // Decode which software-visible register a bus write targets; COUNT and the
    // reserved word are not writable, so they never produce a write strobe.
    always_comb begin
        w_ctrlWrite   = 1'b0;
        w_presetWrite = 1'b0;
        if (bus.we) begin
            case (bus.addr)
                ADDR_CTRL:   w_ctrlWrite   = 1'b1;
                ADDR_PRESET: w_presetWrite = 1'b1;
                default: begin
                    w_ctrlWrite   = 1'b0;
                    w_presetWrite = 1'b0;
                end
            endcase
        end
    end

    assign w_cfgWrite   = w_ctrlWrite | w_presetWrite;
    assign w_autoReload = (r_mode == MODE_PERIODIC);
    // A count of 1 (or a zero preset) means this tick is the terminal one.
    assign w_lastTick   = (r_count <= 32'd1);

    // Counting sequence and register file; a configuration write takes priority
    // over whatever the sequence would otherwise do this cycle.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state   <= S_IDLE;
            r_en      <= 1'b0;
            r_mode    <= 2'd0;
            r_im      <= 1'b0;
            r_preset  <= 32'd0;
            r_count   <= 32'd0;
            r_irqFlag <= 1'b0;
        end else if (w_cfgWrite) begin
            if (w_ctrlWrite) begin
                r_en   <= bus.din[0];
                r_mode <= bus.din[2:1];
                r_im   <= bus.din[3];
            end else begin
                r_preset <= bus.din;
            end
            r_state   <= S_IDLE;
            r_irqFlag <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (r_en) begin
                        r_state <= S_LOAD;
                    end
                end
                S_LOAD: begin
                    r_count <= r_preset;
                    r_state <= S_CNT;
                end
                S_CNT: begin
                    if (!r_en) begin
                        r_state <= S_IDLE;
                    end else if (!w_lastTick) begin
                        r_count <= r_count - 32'd1;
                    end else begin
                        r_count   <= 32'd0;
                        r_irqFlag <= 1'b1;
                        r_state   <= S_INT;
                    end
                end
                S_INT: begin
                    if (w_autoReload) begin
                        r_irqFlag <= 1'b0;
                        r_state   <= S_LOAD;
                    end else begin
                        r_en    <= 1'b0;
                        r_state <= S_IDLE;
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign w_ctrlRead = {28'd0, r_im, r_mode, r_en};

    // Combinational read mux; a read in a write cycle sees the pre-write value.
    always_comb begin
        w_readData = 32'd0;
        case (bus.addr)
            ADDR_CTRL:   w_readData = w_ctrlRead;
            ADDR_PRESET: w_readData = r_preset;
            ADDR_COUNT:  w_readData = r_count;
            default:     w_readData = 32'd0;
        endcase
    end

    assign bus.dout = w_readData;
    assign bus.irq  = r_im & r_irqFlag;

endmodule

// File: tb/tb_timer_dev.sv
// Testbench for timer_dev.
// A time-based model predicts COUNT, the interrupt flag and the en bit from
// the number of edges since the last run started, and is compared against the
// DUT on every cycle; directed scenarios add hand-computed literal checks.
module tb_timer_dev;

    logic clk = 1'b0;
    logic reset = 1'b1;

    int total = 0;
    int bad = 0;

    timer_dev_if bus ();

    timer_dev dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.slave)
    );

    // Free-running 10-unit clock.
    always #5 clk = ~clk;

    // Model state: last software-written values plus an elapsed-edge count
    // for the current run (mK = edges since the enabling write).
    logic        mEn;
    logic        mIm;
    logic [1:0]  mMode;
    logic [31:0] mPreset;
    logic [31:0] mCount;
    bit          mRun = 1'b0;
    longint      mK = 0;
    bit          mValid = 1'b0;

    // Edge index (relative to run start) at which the terminal interrupt occurs.
    function automatic longint intEdge();
        longint n;
        n = longint'(mPreset);
        if (n < 1) n = 1;
        return n + 2;
    endfunction

    function automatic logic [31:0] modelCount();
        longint d;
        longint p;
        if (!mRun || mK < 2) return mCount;
        d = intEdge();
        if (mMode == 2'd1) begin
            p = (mK - 2) % d;
            if (p <= d - 3) return mPreset - 32'(p);
            return 32'd0;
        end
        if (mK < d) return mPreset - 32'(mK - 2);
        return 32'd0;
    endfunction

    function automatic logic modelFlag();
        longint d;
        if (!mRun) return 1'b0;
        d = intEdge();
        if (mMode == 2'd1) return (mK >= 2) && (((mK - 2) % d) == d - 2);
        return mK >= d;
    endfunction

    function automatic logic modelEn();
        if (mRun && mMode != 2'd1 && mK >= intEdge() + 1) return 1'b0;
        return mEn;
    endfunction

    function automatic logic [31:0] modelRead(input logic [1:0] a);
        case (a)
            2'd0:    return {28'd0, mIm, mMode, modelEn()};
            2'd1:    return mPreset;
            2'd2:    return modelCount();
            default: return 32'd0;
        endcase
    endfunction

    // Advance the model at each rising edge from the inputs the bench drove.
    always @(posedge clk) begin
        logic [31:0] cNow;
        logic        eNow;
        cNow = modelCount();
        eNow = modelEn();
        if (reset) begin
            mEn     = 1'b0;
            mIm     = 1'b0;
            mMode   = 2'd0;
            mPreset = 32'd0;
            mCount  = 32'd0;
            mRun    = 1'b0;
            mK      = 0;
            mValid  = 1'b1;
        end else if (bus.we && bus.addr <= 2'd1) begin
            mCount = cNow;
            mEn    = eNow;
            if (bus.addr == 2'd0) begin
                mEn   = bus.din[0];
                mMode = bus.din[2:1];
                mIm   = bus.din[3];
            end else begin
                mPreset = bus.din;
            end
            mRun = mEn;
            mK   = 0;
        end else if (mRun) begin
            mK = mK + 1;
        end
    end

    // Per-cycle comparison of the DUT against the model, away from the active edge.
    always @(negedge clk) begin
        if (mValid) begin
            total = total + 1;
            if (bus.dout !== modelRead(bus.addr)) begin
                bad = bad + 1;
                $display("[TB] FAIL cycle_dout t=%0t addr=%0d got=%h want=%h",
                         $time, bus.addr, bus.dout, modelRead(bus.addr));
            end
            total = total + 1;
            if (bus.irq !== (mIm & modelFlag())) begin
                bad = bad + 1;
                $display("[TB] FAIL cycle_irq t=%0t got=%b want=%b",
                         $time, bus.irq, mIm & modelFlag());
            end
        end
    end

    // Drive one bus cycle; the write (if any) lands on the next rising edge.
    task automatic applyStimulus(input logic [1:0] a, input logic w, input logic [31:0] d);
        bus.addr = a;
        bus.we   = w;
        bus.din  = d;
        @(posedge clk);
        #2;
        bus.we = 1'b0;
    endtask

    task automatic writeReg(input logic [1:0] a, input logic [31:0] d);
        applyStimulus(a, 1'b1, d);
    endtask

    task automatic waitEdges(input int n);
        repeat (n) @(posedge clk);
        #2;
    endtask

    // Hand-computed literal check of read data and interrupt.
    task automatic checkOutput(input string name, input logic [1:0] a,
                               input logic [31:0] expD, input logic expI);
        bus.addr = a;
        #1;
        total = total + 1;
        if (bus.dout !== expD) begin
            bad = bad + 1;
            $display("[TB] FAIL %s dout got=%h want=%h", name, bus.dout, expD);
        end
        total = total + 1;
        if (bus.irq !== expI) begin
            bad = bad + 1;
            $display("[TB] FAIL %s irq got=%b want=%b", name, bus.irq, expI);
        end
    endtask

    logic [31:0] expCnt1 [12] = '{32'd0, 32'd3, 32'd2, 32'd1, 32'd0, 32'd0,
                                  32'd3, 32'd2, 32'd1, 32'd0, 32'd0, 32'd3};

    initial begin
        bus.addr = 2'd0;
        bus.we   = 1'b0;
        bus.din  = 32'd0;

        // Reset state.
        reset = 1'b1;
        repeat (2) @(posedge clk);
        #2;
        reset = 1'b0;
        checkOutput("rst_ctrl", 2'd0, 32'd0, 1'b0);
        checkOutput("rst_preset", 2'd1, 32'd0, 1'b0);
        checkOutput("rst_count", 2'd2, 32'd0, 1'b0);
        checkOutput("rst_rsvd", 2'd3, 32'd0, 1'b0);

        // Mode 0, PRESET 5, im=1.
        $display("[TB] mode 0 one-shot");
        writeReg(2'd1, 32'd5);
        writeReg(2'd0, 32'h9);
        waitEdges(2);
        checkOutput("m0_e2", 2'd2, 32'd5, 1'b0);
        waitEdges(4);
        checkOutput("m0_e6", 2'd2, 32'd1, 1'b0);
        waitEdges(1);
        checkOutput("m0_e7_cnt", 2'd2, 32'd0, 1'b1);
        checkOutput("m0_e7_ctrl", 2'd0, 32'h9, 1'b1);
        waitEdges(1);
        checkOutput("m0_e8_ctrl", 2'd0, 32'h8, 1'b1);
        waitEdges(3);
        checkOutput("m0_hold", 2'd0, 32'h8, 1'b1);
        writeReg(2'd0, 32'h8);
        checkOutput("m0_service", 2'd0, 32'h8, 1'b0);

        // Mode 1 periodic, PRESET 3.
        $display("[TB] mode 1 periodic");
        writeReg(2'd1, 32'd3);
        writeReg(2'd0, 32'hB);
        for (int k = 1; k <= 12; k++) begin
            waitEdges(1);
            checkOutput($sformatf("m1_e%0d", k), 2'd2, expCnt1[k-1], (k == 5 || k == 10));
        end
        writeReg(2'd0, 32'h0);
        checkOutput("m1_stop", 2'd2, 32'd3, 1'b0);

        // Masked interrupt, en still auto-clears.
        $display("[TB] masked one-shot");
        writeReg(2'd1, 32'd5);
        writeReg(2'd0, 32'h1);
        waitEdges(7);
        checkOutput("mask_e7", 2'd2, 32'd0, 1'b0);
        waitEdges(1);
        checkOutput("mask_e8", 2'd0, 32'h0, 1'b0);
        writeReg(2'd0, 32'h0);

        // Disable mid-count then re-enable.
        $display("[TB] disable and re-enable");
        writeReg(2'd1, 32'd100);
        writeReg(2'd0, 32'h9);
        waitEdges(42);
        checkOutput("dis_60", 2'd2, 32'd60, 1'b0);
        writeReg(2'd0, 32'h8);
        checkOutput("dis_frozen", 2'd2, 32'd60, 1'b0);
        waitEdges(5);
        checkOutput("dis_still", 2'd2, 32'd60, 1'b0);
        writeReg(2'd0, 32'h9);
        waitEdges(1);
        checkOutput("reen_e1", 2'd2, 32'd60, 1'b0);
        waitEdges(1);
        checkOutput("reen_e2", 2'd2, 32'd100, 1'b0);
        writeReg(2'd0, 32'h0);

        // PRESET write in the cycle the terminal tick would happen.
        $display("[TB] preset write collides with terminal tick");
        writeReg(2'd1, 32'd4);
        writeReg(2'd0, 32'h9);
        waitEdges(5);
        checkOutput("col_cnt1", 2'd2, 32'd1, 1'b0);
        writeReg(2'd1, 32'd4);
        checkOutput("col_noirq", 2'd2, 32'd1, 1'b0);
        waitEdges(1);
        checkOutput("col_load", 2'd2, 32'd1, 1'b0);
        waitEdges(1);
        checkOutput("col_reload", 2'd2, 32'd4, 1'b0);
        writeReg(2'd0, 32'h0);

        // Writes to COUNT / reserved word are ignored.
        $display("[TB] read-only words");
        writeReg(2'd2, 32'd123);
        writeReg(2'd3, 32'd55);
        checkOutput("ro_count", 2'd2, 32'd4, 1'b0);
        checkOutput("ro_rsvd", 2'd3, 32'd0, 1'b0);
        checkOutput("ro_preset", 2'd1, 32'd4, 1'b0);
        checkOutput("ro_ctrl", 2'd0, 32'd0, 1'b0);

        // PRESET 0 with mode 2 (one-shot alias).
        $display("[TB] preset zero, mode 2");
        writeReg(2'd1, 32'd0);
        writeReg(2'd0, 32'hD);
        waitEdges(2);
        checkOutput("p0_e2", 2'd2, 32'd0, 1'b0);
        waitEdges(1);
        checkOutput("p0_e3", 2'd2, 32'd0, 1'b1);
        waitEdges(1);
        checkOutput("p0_e4", 2'd0, 32'hC, 1'b1);
        writeReg(2'd0, 32'h8);

        // Reset while irq is high.
        $display("[TB] reset during interrupt");
        writeReg(2'd1, 32'd2);
        writeReg(2'd0, 32'h9);
        waitEdges(4);
        checkOutput("rirq_hi", 2'd2, 32'd0, 1'b1);
        reset = 1'b1;
        waitEdges(1);
        checkOutput("rirq_ctrl", 2'd0, 32'd0, 1'b0);
        checkOutput("rirq_preset", 2'd1, 32'd0, 1'b0);
        checkOutput("rirq_count", 2'd2, 32'd0, 1'b0);
        reset = 1'b0;
        waitEdges(3);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
